// File: rtl/lsu_riscv.sv
// Load/store unit: issues one aligned memory access at a time, stalls the core until the
// bus responds, and returns extended load data. Misaligned accesses and bus time-outs are flagged.
module lsu_riscv #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_bus_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  localparam logic [7:0] LAST    = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Alignment check, lane enables and replicated store data for the incoming request.
  always_comb begin
    bad   = 1'b0;
    be    = 4'b0000;
    wdata = lsu_data_i;
    case (lsu_size_i)
      LDST_B, LDST_BU: begin
        be    = 4'b0001 << lsu_addr_i[1:0];
        wdata = {4{lsu_data_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        bad   = lsu_addr_i[0];
        be    = 4'b0011 << lsu_addr_i[1:0];
        wdata = {2{lsu_data_i[15:0]}};
      end
      LDST_W: begin
        bad = |lsu_addr_i[1:0];
        be  = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
  end

  function automatic logic [31:0] extract(input logic [2:0] sz, input logic [1:0] off,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(rd >> {off, 3'b000});
    h = off[1] ? rd[31:16] : rd[15:0];
    case (sz)
      LDST_B:  r = {{24{b[7]}}, b};
      LDST_BU: r = {24'd0, b};
      LDST_H:  r = {{16{h[15]}}, h};
      LDST_HU: r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign lsu_stall_req_o = lsu_req_i & (state != DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      size_q           <= 3'd0;
      off_q            <= 2'd0;
      lsu_data_o       <= 32'd0;
      lsu_misaligned_o <= 1'b0;
      lsu_bus_err_o    <= 1'b0;
      data_req_o       <= 1'b0;
      data_we_o        <= 1'b0;
      data_be_o        <= 4'd0;
      data_addr_o      <= 32'd0;
      data_wdata_o     <= 32'd0;
    end else begin
      lsu_misaligned_o <= 1'b0;
      lsu_bus_err_o    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lsu_req_i) begin
            if (bad) begin
              lsu_misaligned_o <= 1'b1;
              state            <= DONE;
            end else begin
              size_q       <= lsu_size_i;
              off_q        <= lsu_addr_i[1:0];
              data_we_o    <= lsu_we_i;
              data_be_o    <= be;
              data_wdata_o <= wdata;
              data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
              data_req_o   <= 1'b1;
              cnt          <= 8'd0;
              state        <= BUSY;
            end
          end
        end
        BUSY: begin
          // A response in the final wait cycle takes precedence over the time-out.
          if (data_rvalid_i) begin
            if (!data_we_o) lsu_data_o <= extract(size_q, off_q, data_rdata_i);
            data_req_o <= 1'b0;
            state      <= DONE;
          end else if (cnt == LAST) begin
            lsu_bus_err_o <= 1'b1;
            data_req_o    <= 1'b0;
            state         <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_riscv.sv
// Scoreboarded bench for lsu_riscv: directed accesses push expected bus and core-side
// results; independent monitors pop and compare as the DUT presents them.
module tb_lsu_riscv;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic        lsu_stall_req_o, lsu_misaligned_o, lsu_bus_err_o;
  logic [31:0] lsu_data_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic        data_rvalid_i;

  // Memory responder controls and a manual override for the late-response case.
  logic        rsp_en = 1'b0, rsp_rvalid = 1'b0, man_rvalid = 1'b0;
  int          rsp_lat = 1, rsp_cnt = 0;
  logic [31:0] rsp_rdata = '0, man_rdata = '0;

  assign data_rvalid_i = rsp_rvalid | man_rvalid;
  assign data_rdata_i  = man_rvalid ? man_rdata : rsp_rdata;

  lsu_riscv #(.MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o),
    .lsu_misaligned_o(lsu_misaligned_o), .lsu_bus_err_o(lsu_bus_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        err;
    int          stall;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          cycles;
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int    checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: raises rvalid during the lat-th cycle that data_req_o is high.
  always @(negedge clk) begin
    if (data_req_o && rsp_en) begin
      rsp_cnt++;
      rsp_rvalid <= (rsp_cnt == rsp_lat);
    end else begin
      rsp_cnt = 0;
      rsp_rvalid <= 1'b0;
    end
  end

  // Bus-side monitor.
  logic req_prev = 1'b0;
  int   req_cnt = 0;
  bus_t bcur;
  always @(negedge clk) begin
    if (data_req_o === 1'b1 && !req_prev) begin
      chk("bus_expected", 32'(bq.size() != 0), 32'd1);
      if (bq.size() != 0) begin
        bcur = bq.pop_front();
        chk("data_addr", data_addr_o, bcur.addr);
        chk("data_be", 32'(data_be_o), 32'(bcur.be));
        chk("data_we", 32'(data_we_o), 32'(bcur.we));
        chk("data_wdata", data_wdata_o, bcur.wdata);
      end
      req_cnt = 0;
    end
    if (data_req_o === 1'b1) req_cnt++;
    if (data_req_o !== 1'b1 && req_prev) chk("req_cycles", 32'(req_cnt), 32'(bcur.cycles));
    req_prev = (data_req_o === 1'b1);
  end

  // Core-side monitor: the retire cycle is req high with stall low.
  int    stall_cnt = 0;
  resp_t rcur;
  always @(negedge clk) begin
    if (lsu_req_i && lsu_stall_req_o) begin
      stall_cnt++;
    end else if (lsu_req_i && !lsu_stall_req_o) begin
      chk("resp_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        rcur = rq.pop_front();
        chk("lsu_data", lsu_data_o, rcur.data);
        chk("misaligned", 32'(lsu_misaligned_o), 32'(rcur.mis));
        chk("bus_err", 32'(lsu_bus_err_o), 32'(rcur.err));
        chk("stall_cycles", 32'(stall_cnt), 32'(rcur.stall));
      end
      stall_cnt = 0;
    end else begin
      stall_cnt = 0;
    end
    if (rst_n_i === 1'b1 && !(lsu_req_i && !lsu_stall_req_o))
      chk("no_stray_pulse", 32'(lsu_misaligned_o | lsu_bus_err_o), 32'd0);
  end

  task automatic acc(input logic we, input logic [2:0] sz, input logic [31:0] addr, d, rdata,
                     input int lat, input logic [31:0] xdata, input logic xmis, xerr,
                     input logic [3:0] xbe, input logic [31:0] xwd);
    int n;
    bus_t  b;
    resp_t r;
    if (!xmis) begin
      b = '{addr: {addr[31:2], 2'b00}, be: xbe, we: we, wdata: xwd, cycles: xerr ? 4 : lat};
      bq.push_back(b);
    end
    r = '{data: xdata, mis: xmis, err: xerr, stall: xmis ? 1 : (xerr ? 5 : lat + 1)};
    rq.push_back(r);
    @(posedge clk); #1;
    rsp_en = !xerr; rsp_lat = lat; rsp_rdata = rdata;
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = addr; lsu_data_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lsu_stall_req_o && n < 60);
    if (n >= 60) chk("stall_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_data_i = '0;
  endtask

  initial begin
    rst_n_i = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = '0;
    lsu_addr_i = '0; lsu_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_req", 32'(data_req_o), 32'd0);
    chk("rst_stall", 32'(lsu_stall_req_o), 32'd0);
    chk("rst_lsu_data", lsu_data_o, 32'd0);
    chk("rst_flags", 32'({lsu_misaligned_o, lsu_bus_err_o, data_we_o}), 32'd0);
    chk("rst_be", 32'(data_be_o), 32'd0);
    chk("rst_addr_wdata", data_addr_o | data_wdata_o, 32'd0);
    @(posedge clk); #1 rst_n_i = 1'b1;

    //   we  sz    addr          d             rdata         lat data          mis   err   be       wdata
    acc(1'b0, 3'd0, 32'h103, 32'h0,        32'h80112233, 2, 32'hFFFFFF80, 1'b0, 1'b0, 4'b1000, 32'h0);
    acc(1'b0, 3'd5, 32'h202, 32'h0,        32'hBEEF1234, 1, 32'h0000BEEF, 1'b0, 1'b0, 4'b1100, 32'h0);
    acc(1'b0, 3'd1, 32'h202, 32'h0,        32'hBEEF1234, 1, 32'hFFFFBEEF, 1'b0, 1'b0, 4'b1100, 32'h0);
    acc(1'b1, 3'd1, 32'h006, 32'hAAAA5678, 32'hDEADBEEF, 3, 32'hFFFFBEEF, 1'b0, 1'b0, 4'b1100, 32'h56785678);
    acc(1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        1, 32'hFFFFBEEF, 1'b1, 1'b0, 4'b0000, 32'h0);
    acc(1'b0, 3'd3, 32'h000, 32'h0,        32'h0,        1, 32'hFFFFBEEF, 1'b1, 1'b0, 4'b0000, 32'h0);
    acc(1'b0, 3'd2, 32'h040, 32'h0,        32'h0,        1, 32'hFFFFBEEF, 1'b0, 1'b1, 4'b1111, 32'h0);
    acc(1'b0, 3'd2, 32'h020, 32'h0,        32'h0BADC0DE, 4, 32'h0BADC0DE, 1'b0, 1'b0, 4'b1111, 32'h0);
    acc(1'b0, 3'd4, 32'h101, 32'h0,        32'h1234F0AB, 1, 32'h000000F0, 1'b0, 1'b0, 4'b0010, 32'h0);
    acc(1'b0, 3'd0, 32'h101, 32'h0,        32'h1234F0AB, 1, 32'hFFFFFFF0, 1'b0, 1'b0, 4'b0010, 32'h0);
    acc(1'b1, 3'd0, 32'h002, 32'h123456A5, 32'h0,        2, 32'hFFFFFFF0, 1'b0, 1'b0, 4'b0100, 32'hA5A5A5A5);
    acc(1'b1, 3'd2, 32'h010, 32'hCAFEF00D, 32'h0,        1, 32'hFFFFFFF0, 1'b0, 1'b0, 4'b1111, 32'hCAFEF00D);
    acc(1'b0, 3'd2, 32'h010, 32'h0,        32'h76543210, 2, 32'h76543210, 1'b0, 1'b0, 4'b1111, 32'h0);
    acc(1'b0, 3'd1, 32'h003, 32'h0,        32'h0,        1, 32'h76543210, 1'b1, 1'b0, 4'b0000, 32'h0);
    acc(1'b1, 3'd6, 32'h008, 32'h11111111, 32'h0,        1, 32'h76543210, 1'b1, 1'b0, 4'b0000, 32'h0);
    acc(1'b0, 3'd1, 32'h000, 32'h0,        32'h12348001, 1, 32'hFFFF8001, 1'b0, 1'b0, 4'b0011, 32'h0);

    // Reset in the middle of an access, then a late response that must be ignored.
    bq.push_back('{addr: 32'h80, be: 4'b1111, we: 1'b0, wdata: 32'h0, cycles: 2});
    @(posedge clk); #1;
    rsp_en = 1'b0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h80;
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b0; lsu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_n_i = 1'b1; man_rdata = 32'h12345678; man_rvalid = 1'b1;
    @(negedge clk);
    chk("rst_busy_data_req", 32'(data_req_o), 32'd0);
    chk("rst_busy_lsu_data", lsu_data_o, 32'd0);
    @(posedge clk); #1 man_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_data_req", 32'(data_req_o), 32'd0);
    chk("late_rvalid_lsu_data", lsu_data_o, 32'd0);

    acc(1'b0, 3'd5, 32'h000, 32'h0,        32'h00018001, 1, 32'h00008001, 1'b0, 1'b0, 4'b0011, 32'h0);

    repeat (3) @(posedge clk);
    chk("bus_queue_drained", 32'(bq.size()), 32'd0);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
